// File: rtl/exgcd_sched_if.sv
// rtl/exgcd_sched_if.sv - request, engine and response bus bundle for exgcd_sched
interface exgcd_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;

    logic              eng_valid;
    logic [W-1:0]      eng_a;
    logic [W-1:0]      eng_b;
    logic              eng_done;
    logic [W-1:0]      eng_gcd;
    logic [W-1:0]      eng_inv;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic [W-1:0]      rsp_inv;
    logic              rsp_err;

    logic              busy;

    // Requesters, engine and response consumer side
    modport master (
        output req_valid, req_a, req_b,
        output eng_done, eng_gcd, eng_inv,
        output rsp_ready,
        input  req_ready,
        input  eng_valid, eng_a, eng_b,
        input  rsp_valid, rsp_id, rsp_gcd, rsp_inv, rsp_err,
        input  busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_a, req_b,
        input  eng_done, eng_gcd, eng_inv,
        input  rsp_ready,
        output req_ready,
        output eng_valid, eng_a, eng_b,
        output rsp_valid, rsp_id, rsp_gcd, rsp_inv, rsp_err,
        output busy
    );
endinterface

// File: rtl/exgcd_sched.sv
// rtl/exgcd_sched.sv - round-robin scheduler sharing one extended-GCD engine
module exgcd_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    exgcd_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    // Last counter value still inside the wait window; reaching it without
    // eng_done means the engine has used up its whole budget.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [15:0]    cnt;

    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   grant_a;
    logic [W-1:0]   grant_b;

    // Rotating priority search: first valid requester after ptr wins.
    // Scanning from the farthest candidate down lets the nearest one overwrite.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == (int'(ptr) + k) % NREQ && bus.req_valid[i]) begin
                    grant_any = 1'b1;
                    grant_id  = IDW'(i);
                end
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                grant_a = bus.req_a[i*W +: W];
                grant_b = bus.req_b[i*W +: W];
            end
        end
    end

    // One-hot accept strobe, only while idle and out of reset
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == S_IDLE && grant_any) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_id == IDW'(i)) begin
                    bus.req_ready[i] = 1'b1;
                end
            end
        end
    end

    // Scheduler FSM with registered engine and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= IDW'(NREQ - 1);
            id_q          <= '0;
            cnt           <= '0;
            bus.eng_valid <= 1'b0;
            bus.eng_a     <= '0;
            bus.eng_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_gcd   <= '0;
            bus.rsp_inv   <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        id_q      <= grant_id;
                        bus.eng_a <= grant_a;
                        bus.eng_b <= grant_b;
                        bus.busy  <= 1'b1;
                        if (grant_b != '0) begin
                            bus.eng_valid <= 1'b1;
                            state         <= S_ISSUE;
                        end else begin
                            // gcd(a, 0) = a needs no engine round trip
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_id    <= grant_id;
                            bus.rsp_gcd   <= grant_a;
                            bus.rsp_inv   <= '0;
                            bus.rsp_err   <= 1'b0;
                            state         <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    bus.eng_valid <= 1'b0;
                    cnt           <= '0;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (bus.eng_done) begin
                        state <= S_CAPT;
                    end else if (cnt == CNT_LAST) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= id_q;
                        bus.rsp_gcd   <= '0;
                        bus.rsp_inv   <= '0;
                        bus.rsp_err   <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_CAPT: begin
                    // Engine results are only guaranteed stable one cycle after done
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_id    <= id_q;
                    bus.rsp_gcd   <= bus.eng_gcd;
                    bus.rsp_inv   <= bus.eng_inv;
                    bus.rsp_err   <= 1'b0;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        ptr           <= id_q;
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/exgcd_sched.md
Name: exgcd_sched

Overview:
- Round-robin scheduler that shares one extended-GCD engine between NREQ requesters.
- Each requester offers an operand pair (a, b). The block grants one pair at a time, issues it to the engine and waits for completion. It then returns gcd/inv on a shared response bus, tagged with the requester id.
- It short-circuits b==0 without using the engine, and aborts with an error if the engine does not finish within TIMEOUT cycles.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width
IDW, 2, requester id width, equal to clog2(NREQ)
TIMEOUT, 255, max cycles spent in WAIT before abort (1..2^16-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; the clock is single and reset is asynchronous, active-low
req_valid  in  NREQ  per-requester request valid; held until accepted
req_ready  out  NREQ  one-hot accept strobe, combinational, IDLE only
req_a  in  NREQ*W  operand a; requester i occupies bits [i*W +: W]
req_b  in  NREQ*W  operand b, same packing
eng_valid  out  1  one-cycle start pulse to the engine
eng_a  out  W  operand a to the engine (registered)
eng_b  out  W  operand b to the engine (registered)
eng_done  in  1  engine completion pulse
eng_gcd  in  W  engine gcd; stable from the cycle after eng_done
eng_inv  in  W  engine inverse; stable from the cycle after eng_done
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  id of the requester being answered
rsp_gcd  out  W  result gcd
rsp_inv  out  W  result inverse (a^-1 mod b when gcd==1)
rsp_err  out  1  1 = engine timeout; gcd and inv are 0
busy  out  1  high whenever state != IDLE

Behaviour:

Reset values:
- All outputs 0. State IDLE. Round-robin pointer ptr = NREQ-1, so requester 0 wins first. Timeout counter 0.
- Reset asserted mid-operation aborts everything immediately. The engine is not notified, and a late eng_done after reset is ignored because the state is IDLE.

States: IDLE, ISSUE, WAIT, CAPT, RESP.

IDLE:
- If any req_valid is set, the winner g is the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
- req_ready[g]=1 in that cycle. a, b and id=g are latched.
- If b!=0, go to ISSUE. If b==0 (bypass), load rsp_gcd=a, rsp_inv=0, rsp_err=0 and go to RESP.
- a==0 with b!=0 goes through the engine normally.

ISSUE:
- eng_valid=1 for exactly this cycle. eng_a/eng_b carry the latched operands and hold through WAIT.
- Clear the counter and go to WAIT.

WAIT:
- Counter increments every cycle.
- eng_done=1: go to CAPT. eng_done has priority over timeout in the same cycle.
- Otherwise, when counter==TIMEOUT-1: load rsp_gcd=0, rsp_inv=0, rsp_err=1 and go to RESP.

CAPT:
- Register eng_gcd/eng_inv into rsp_gcd/rsp_inv, set rsp_err=0, go to RESP.

RESP:
- rsp_valid=1 with stable rsp_id/gcd/inv/err until the cycle rsp_ready=1.
- In that handshake cycle: ptr <= id, go to IDLE, and rsp_valid drops the next cycle.
- No new grant is made in the handshake cycle, so there is at most one job outstanding.

Other rules:
- eng_done outside WAIT is ignored.
- req_ready is 0 in every state except IDLE.

Latency (acceptance at cycle T, eng_done at cycle D):
- Engine path: eng_valid at T+1, rsp_valid from D+2.
- Bypass: rsp_valid at T+1.
- Timeout: rsp_valid at T+2+TIMEOUT.

Fairness:
- After requester i is served, i has the lowest priority.
- With all NREQ requesters continuously valid, grants rotate 0,1,2,3,0...

Test Plan:
1. Single request. Requester 2 sends a=35, b=15. Engine model pulses eng_done 6 cycles after eng_valid, with gcd=5, inv=0x03. Required: eng_a=35, eng_b=15, one eng_valid pulse, then rsp_id=2, gcd=5, inv=3, err=0, with rsp_valid exactly 2 cycles after eng_done.
2. Round-robin. All 4 requesters valid continuously, rsp_ready tied to 1. Required: grant order 0,1,2,3,0; each req_ready is a one-cycle pulse; never two bits set at once.
3. Bypass. Requester 1 sends a=9, b=0. Required: eng_valid never asserts; rsp_valid one cycle after acceptance with gcd=9, inv=0, err=0.
4. Timeout. TIMEOUT=20 and the engine never responds. Required: rsp_err=1, gcd=0, inv=0 at T+22. A later eng_done is ignored, and the next request proceeds normally.
5. Backpressure. rsp_ready held low 10 cycles, with requester 3 also valid. Required: rsp fields stable, req_ready[3] stays 0 until 1 cycle after the handshake, then requester 3 is granted.
6. Reset mid-WAIT. Drop rst_n for 1 cycle during WAIT. Required: all outputs 0, IDLE, requester 0 wins next; a stray eng_done produces no response.
